// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub opcode encoding, default datapath width
// and the helper that sizes the carry-chain chunks of pipelined adders.
package alu_pkg;

    typedef enum logic {
        ALU_OP_ADD = 1'b0,
        ALU_OP_SUB = 1'b1
    } alu_op_e;

    localparam int ALU_WIDTH  = 32;
    localparam int ALU_STAGES = 4;

    // Returns 0 for an illegal split so the caller can stop elaboration.
    function automatic int chunk_width(input int width, input int stages);
        if (width < 2 || stages < 1 || (width % stages) != 0) begin
            return 0;
        end
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result streaming bus of the pipelined add/sub unit; the producer and
// consumer side both live on the master modport, the unit on the slave modport.
interface pipe_addsub_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             i_carry;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, i_carry, sub, out_ready,
        input  in_ready, out_valid, o_sum, o_carry, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, i_carry, sub, out_ready,
        output in_ready, out_valid, o_sum, o_carry, overflow, zero
    );
endinterface

// File: rtl/addsub_slice.sv
// One pipeline stage: adds chunk K of the travelling operands with the carry
// from the previous stage and registers the beat when the stage is enabled.
module addsub_slice
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int C     = 8,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    input  logic             i_zero,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_b,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_ovf
);
    logic [C-1:0]     w_a;
    logic [C-1:0]     w_bc;
    logic [C:0]       w_chunk;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_ovf;

    logic             r_valid;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic             r_zero;
    logic             r_ovf;

    // i_acc holds result chunks below K and still-unsummed A chunks from K up.
    assign w_a     = i_acc[K*C +: C];
    assign w_bc    = i_b[K*C +: C];
    assign w_chunk = {1'b0, w_a} + {1'b0, w_bc} + {{C{1'b0}}, i_carry};
    assign w_ovf   = (w_a[C-1] == w_bc[C-1]) && (w_chunk[C-1] != w_a[C-1]);

    // NOTE: assign the full default before the partial overwrite so no bit is left unassigned on any path, which would infer a latch.
    always_comb begin
        w_acc_next             = i_acc;
        w_acc_next[K*C +: C]   = w_chunk[C-1:0];
    end

    // NOTE: the payload is reset too, because the result outputs must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (i_en) begin
            // NOTE: non-blocking assignments so every stage samples its upstream neighbour's pre-edge value.
            r_valid <= i_valid;
            if (i_valid) begin
                r_acc   <= w_acc_next;
                r_b     <= i_b;
                r_carry <= w_chunk[C];
                r_zero  <= i_zero && (w_chunk[C-1:0] == '0);
                r_ovf   <= w_ovf;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_acc   = r_acc;
    assign o_b     = r_b;
    assign o_carry = r_carry;
    assign o_zero  = r_zero;
    assign o_ovf   = r_ovf;
endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit: STAGES slices of WIDTH/STAGES bits each, with a
// valid/ready handshake that streams one beat per cycle and absorbs backpressure.
module pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = ALU_STAGES
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_addsub_if.slave  bus
);
    localparam int C = chunk_width(WIDTH, STAGES);

    if (C == 0) begin : g_param_check
        $error("pipe_addsub: WIDTH must be >= 2 and an exact multiple of STAGES");
    end

    // Index 0 is the captured input beat; index k+1 is the register of stage k.
    logic             w_valid [STAGES+1];
    logic [WIDTH-1:0] w_acc   [STAGES+1];
    logic [WIDTH-1:0] w_b     [STAGES+1];
    logic             w_carry [STAGES+1];
    logic             w_zero  [STAGES+1];
    logic             w_ovf   [STAGES];
    logic [STAGES:0]  w_ready;
    logic             w_sub;

    assign w_sub      = (alu_op_e'(bus.sub) == ALU_OP_SUB);
    assign w_valid[0] = bus.in_valid;
    assign w_acc[0]   = bus.a;
    assign w_b[0]     = w_sub ? ~bus.b : bus.b;
    assign w_carry[0] = w_sub ? ~bus.i_carry : bus.i_carry;
    assign w_zero[0]  = 1'b1;

    // Stage k may load when any stage from k downward has a hole or the
    // consumer takes the head beat; flattened so the chain has no feedback.
    always_comb begin
        for (int k = 0; k <= STAGES; k++) begin
            logic v_free;
            v_free = bus.out_ready;
            for (int j = k; j < STAGES; j++) begin
                v_free = v_free | !w_valid[j+1];
            end
            w_ready[k] = v_free;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_slice #(
            .WIDTH (WIDTH),
            .C     (C),
            .K     (k)
        ) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_ready[k]),
            .i_valid (w_valid[k]),
            .i_acc   (w_acc[k]),
            .i_b     (w_b[k]),
            .i_carry (w_carry[k]),
            .i_zero  (w_zero[k]),
            .o_valid (w_valid[k+1]),
            .o_acc   (w_acc[k+1]),
            .o_b     (w_b[k+1]),
            .o_carry (w_carry[k+1]),
            .o_zero  (w_zero[k+1]),
            .o_ovf   (w_ovf[k])
        );
    end

    assign bus.in_ready  = w_ready[0];
    assign bus.out_valid = w_valid[STAGES];
    assign bus.o_sum     = w_acc[STAGES];
    assign bus.o_carry   = w_carry[STAGES];
    assign bus.overflow  = w_ovf[STAGES-1];
    assign bus.zero      = w_zero[STAGES];
endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed vectors on a 32/4 instance plus
// latency and constrained-random sweeps on 8/1, 16/2 and 64/8 instances.
module tb_pipe_addsub;
    import alu_pkg::*;

    typedef logic [66:0] res_t;   // {overflow, zero, carry, sum zero-extended to 64}

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_addsub_if #(.WIDTH(32)) if32 ();
    pipe_addsub_if #(.WIDTH(8))  if8  ();
    pipe_addsub_if #(.WIDTH(16)) if16 ();
    pipe_addsub_if #(.WIDTH(64)) if64 ();

    pipe_addsub #(.WIDTH(32), .STAGES(4)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    pipe_addsub #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    pipe_addsub #(.WIDTH(16), .STAGES(2)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    pipe_addsub #(.WIDTH(64), .STAGES(8)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    // Shared stimulus for the three secondary instances, consumer always ready.
    logic        x_valid = 1'b0;
    logic [63:0] x_a     = '0;
    logic [63:0] x_b     = '0;
    logic        x_ci    = 1'b0;
    logic        x_sub   = 1'b0;

    assign if8.in_valid  = x_valid;
    assign if8.a         = x_a[7:0];
    assign if8.b         = x_b[7:0];
    assign if8.i_carry   = x_ci;
    assign if8.sub       = x_sub;
    assign if8.out_ready = 1'b1;
    assign if16.in_valid  = x_valid;
    assign if16.a         = x_a[15:0];
    assign if16.b         = x_b[15:0];
    assign if16.i_carry   = x_ci;
    assign if16.sub       = x_sub;
    assign if16.out_ready = 1'b1;
    assign if64.in_valid  = x_valid;
    assign if64.a         = x_a;
    assign if64.b         = x_b;
    assign if64.i_carry   = x_ci;
    assign if64.sub       = x_sub;
    assign if64.out_ready = 1'b1;

    res_t q32[$];
    res_t q8[$];
    res_t q16[$];
    res_t q64[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   acc32 = 0;

    task automatic check(input string tag, input res_t got, input res_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t expv(input logic [63:0] s, input logic c, input logic ov, input logic z);
        return {ov, z, c, s};
    endfunction

    // Reference: plain wide arithmetic on the whole word.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic sb);
        logic [63:0] mask, am, be, s;
        logic [64:0] full;
        logic        ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        be   = (sb ? ~b : b) & mask;
        full = {1'b0, am} + {1'b0, be} + {64'b0, (sb ? ~ci : ci)};
        s    = full[63:0] & mask;
        ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
        return {ov, (s == '0), full[w], s};
    endfunction

    function automatic res_t obs32();
        return {if32.overflow, if32.zero, if32.o_carry, 32'b0, if32.o_sum};
    endfunction

    // Scoreboards: every beat taken by the consumer must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && if32.out_valid && if32.out_ready) begin
            if (q32.size() == 0) check("stray32", {66'b0, if32.out_valid}, '0);
            else check("res32", obs32(), q32.pop_front());
        end
    end
    always @(negedge clk) begin
        if (rst_n && if8.out_valid) begin
            if (q8.size() == 0) check("stray8", {66'b0, if8.out_valid}, '0);
            else check("res8", {if8.overflow, if8.zero, if8.o_carry, 56'b0, if8.o_sum}, q8.pop_front());
        end
    end
    always @(negedge clk) begin
        if (rst_n && if16.out_valid) begin
            if (q16.size() == 0) check("stray16", {66'b0, if16.out_valid}, '0);
            else check("res16", {if16.overflow, if16.zero, if16.o_carry, 48'b0, if16.o_sum}, q16.pop_front());
        end
    end
    always @(negedge clk) begin
        if (rst_n && if64.out_valid) begin
            if (q64.size() == 0) check("stray64", {66'b0, if64.out_valid}, '0);
            else check("res64", {if64.overflow, if64.zero, if64.o_carry, if64.o_sum}, q64.pop_front());
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic sb, input res_t exp, output int waited);
        if32.a = a;
        if32.b = b;
        if32.i_carry = ci;
        if32.sub = sb;
        if32.in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!if32.in_ready && waited < 60) begin
            waited++;
            @(negedge clk);
        end
        if (if32.in_ready) begin
            q32.push_back(exp);
            acc32++;
        end else begin
            check("accept32_timeout", {66'b0, if32.in_ready}, 67'd1);
        end
        @(posedge clk);
        #1;
        if32.in_valid = 1'b0;
    endtask

    task automatic send_burst();
        int w;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] pa, pb;
            logic        pc, ps;
            pa = 32'(i) * 32'h2345_6789;
            pb = 32'(i + 1) * 32'h1111_1111;
            pc = (i % 4) >= 2;
            ps = (i % 2) == 1;
            send32(pa, pb, pc, ps, model(32, {32'b0, pa}, {32'b0, pb}, pc, ps), w);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q32.size() + q8.size() + q16.size() + q64.size()) != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("drain_left", 67'(q32.size() + q8.size() + q16.size() + q64.size()), '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   w, wt, lat;
        res_t first_exp;

        if32.in_valid  = 1'b0;
        if32.a         = '0;
        if32.b         = '0;
        if32.i_carry   = 1'b0;
        if32.sub       = 1'b0;
        if32.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {66'b0, if32.out_valid}, '0);
        check("rst_outputs", obs32(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {66'b0, if32.in_ready}, 67'd1);

        // 1. single add and latency
        send32(32'd1123, 32'd1312, 1'b1, ALU_OP_ADD, expv(64'd2436, 1'b0, 1'b0, 1'b0), w);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if32.out_valid && lat < 20);
        check("lat32", 67'(lat), 67'd4);
        @(posedge clk);
        #1;

        // 2. back-to-back stream, including wrap to zero
        wt = 0;
        send32(32'd123, 32'd421, 1'b1, ALU_OP_ADD, expv(64'd545, 1'b0, 1'b0, 1'b0), w);
        wt += w;
        send32(32'd123, 32'd432, 1'b1, ALU_OP_ADD, expv(64'd556, 1'b0, 1'b0, 1'b0), w);
        wt += w;
        send32(32'hFFFF_FFFF, 32'd1, 1'b0, ALU_OP_ADD, expv(64'd0, 1'b1, 1'b0, 1'b1), w);
        wt += w;
        check("b2b_ready_stalls", 67'(wt), '0);
        drain();

        // 3. signed overflow and borrow corners
        send32(32'h7FFF_FFFF, 32'd1, 1'b0, ALU_OP_ADD, expv(64'h8000_0000, 1'b0, 1'b1, 1'b0), w);
        send32(32'd5, 32'd7, 1'b0, ALU_OP_SUB, expv(64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0), w);
        send32(32'h8000_0000, 32'd1, 1'b0, ALU_OP_SUB, expv(64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), w);
        send32(32'd10, 32'd3, 1'b1, ALU_OP_SUB, expv(64'd6, 1'b1, 1'b0, 1'b0), w);
        drain();

        // 4. backpressure: pipe fills to 4, head holds, then all 6 emerge in order
        first_exp = model(32, 64'd0, 64'h1111_1111, 1'b0, 1'b0);
        acc32 = 0;
        if32.out_ready = 1'b0;
        fork
            send_burst();
        join_none
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_accepts", 67'(acc32), 67'd4);
        check("bp_in_ready", {66'b0, if32.in_ready}, '0);
        check("bp_out_valid", {66'b0, if32.out_valid}, 67'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_out", obs32(), first_exp);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if32.out_ready = 1'b1;
        wait fork;
        drain();
        check("bp_all_accepted", 67'(acc32), 67'd6);

        // 5. reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            send32(32'(i + 10), 32'd3, 1'b0, ALU_OP_ADD,
                   model(32, 64'(i + 10), 64'd3, 1'b0, 1'b0), w);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {66'b0, if32.out_valid}, '0);
        check("mid_rst_outputs", obs32(), '0);
        q32.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {66'b0, if32.in_ready}, 67'd1);
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_no_stale", {66'b0, if32.out_valid}, '0);
        send32(32'd1, 32'd1, 1'b0, ALU_OP_ADD, expv(64'd2, 1'b0, 1'b0, 1'b0), w);
        drain();

        // 6. single-stage instance: wrap to zero with latency 1
        x_a = 64'hFF;
        x_b = 64'h01;
        x_ci = 1'b0;
        x_sub = ALU_OP_ADD;
        x_valid = 1'b1;
        @(negedge clk);
        q8.push_back(expv(64'h0, 1'b1, 1'b0, 1'b1));
        q16.push_back(model(16, x_a, x_b, x_ci, x_sub));
        q64.push_back(model(64, x_a, x_b, x_ci, x_sub));
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if8.out_valid && lat < 20);
        check("lat8", 67'(lat), 67'd1);
        drain();

        // Constrained-random sweep over 8/1, 16/2 and 64/8 with corner operands
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0: begin x_a = {$urandom, $urandom}; x_b = {$urandom, $urandom}; end
                1: begin x_a = '1; x_b = 64'($urandom_range(0, 3)); end
                2: begin x_a = 64'h8000_0000_0000_8080; x_b = (i % 8 == 2) ? x_a : 64'd1; end
                default: begin x_a = {$urandom, $urandom}; x_b = x_a; end
            endcase
            x_ci = 1'($urandom_range(0, 1));
            x_sub = 1'($urandom_range(0, 1));
            x_valid = 1'b1;
            @(negedge clk);
            check("sweep_in_ready", {64'b0, if8.in_ready, if16.in_ready, if64.in_ready}, 67'd7);
            q8.push_back(model(8, x_a, x_b, x_ci, x_sub));
            q16.push_back(model(16, x_a, x_b, x_ci, x_sub));
            q64.push_back(model(64, x_a, x_b, x_ci, x_sub));
            @(posedge clk);
            #1;
        end
        x_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1);
    end
endmodule
